// File: rtl/quant_pkg.sv
// Shared constants for the JPEG quantiser: block geometry, component
// encodings, table selectors and a reciprocal helper.
package quant_pkg;

  localparam int BLOCK_COEFFS = 64;

  typedef enum logic [1:0] {
    COMP_Y     = 2'd0,
    COMP_CB    = 2'd1,
    COMP_CR    = 2'd2,
    COMP_ALT_Y = 2'd3
  } comp_e;

  localparam logic TBL_LUMA   = 1'b0;
  localparam logic TBL_CHROMA = 1'b1;

  // Reciprocal table entry for quantiser step q: round(2^recip_w / q).
  function automatic int recip_of(input int q, input int recip_w = 16);
    return ((1 << recip_w) + q / 2) / q;
  endfunction

endpackage

// File: rtl/quant_lane.sv
// One quantiser lane: |x| * recip in the first stage, then round half away
// from zero, reapply sign and saturate in the second stage.
module quant_lane
  import quant_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int OUT_W   = 8,
  parameter int RECIP_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               adv,
  input  logic [IN_W-1:0]    x,
  input  logic [RECIP_W:0]   recip,
  output logic [OUT_W-1:0]   q,
  output logic               sat
);

  // Product width leaves headroom for |x| = 2^(IN_W-1) and the rounding add.
  localparam int M_W = IN_W + RECIP_W + 2;
  localparam logic [M_W-1:0] HALF    = {{(M_W-RECIP_W){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
  localparam logic [M_W-1:0] POS_MAX = {{(M_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [M_W-1:0] NEG_MAG = {{(M_W-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W:0]    x_ext;
  logic [IN_W:0]    abs_x;
  logic [M_W-1:0]   prod;
  logic [M_W-1:0]   rnd;
  logic [M_W-1:0]   m_reg;
  logic             neg_reg;
  logic [OUT_W-1:0] q_next;
  logic [OUT_W-1:0] q_reg;
  logic             sat_next;
  logic             sat_reg;

  // Magnitude is taken one bit wider so the most negative input cannot overflow.
  assign x_ext = {x[IN_W-1], x};
  assign abs_x = x[IN_W-1] ? -x_ext : x_ext;
  assign prod  = M_W'(abs_x) * M_W'(recip);
  assign rnd   = (m_reg + HALF) >> RECIP_W;

  // Round on the magnitude, then clamp against the asymmetric signed range.
  always_comb begin
    q_next   = '0;
    sat_next = 1'b0;
    if (neg_reg) begin
      if (rnd > NEG_MAG) begin
        q_next   = {1'b1, {(OUT_W-1){1'b0}}};
        sat_next = 1'b1;
      end else begin
        q_next = OUT_W'(-rnd);
      end
    end else begin
      if (rnd > POS_MAX) begin
        q_next   = {1'b0, {(OUT_W-1){1'b1}}};
        sat_next = 1'b1;
      end else begin
        q_next = OUT_W'(rnd);
      end
    end
  end

  // Both data stages advance together under the shared pipeline enable.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_reg   <= '0;
      neg_reg <= 1'b0;
      q_reg   <= '0;
      sat_reg <= 1'b0;
    end else if (adv) begin
      m_reg   <= prod;
      neg_reg <= x[IN_W-1];
      q_reg   <= q_next;
      sat_reg <= sat_next;
    end
  end

  assign q   = q_reg;
  assign sat = sat_reg;

endmodule

// File: rtl/quant_pipe.sv
// Parametrised JPEG quantiser: LANES coefficients per beat, loadable luma and
// chroma reciprocal tables, two-stage pipeline with valid/ready on both sides.
module quant_pipe
  import quant_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int IN_W    = 12,
  parameter int OUT_W   = 8,
  parameter int RECIP_W = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_comp,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic                   out_last,
  input  logic                   tbl_we,
  input  logic                   tbl_sel,
  input  logic [5:0]             tbl_addr,
  input  logic [RECIP_W:0]       tbl_data,
  output logic                   tbl_err,
  output logic [15:0]            blk_count
);

  localparam int BEATS = BLOCK_COEFFS / LANES;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
  localparam logic [RECIP_W:0] RECIP_ONE = {1'b1, {RECIP_W{1'b0}}};

  logic [BW-1:0]    beat_reg;
  logic             chroma_reg;
  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic             tbl_err_reg;
  logic [15:0]      blk_count_reg;
  logic [RECIP_W:0] tbl_reg [2][BLOCK_COEFFS];

  logic adv;
  logic idle;
  logic fire;
  logic tbl_wr_ok;
  logic beat_chroma;

  assign adv       = ~out_valid_reg | out_ready;
  assign idle      = (beat_reg == '0) & ~s1_valid_reg & ~out_valid_reg;
  assign in_ready  = adv & ~(tbl_we & idle);
  assign fire      = in_valid & in_ready;
  assign tbl_wr_ok = tbl_we & idle;
  // Beat 0 looks at the live component; later beats use the latched one.
  assign beat_chroma = (beat_reg == '0) ? ((in_comp == COMP_CB) || (in_comp == COMP_CR))
                                        : chroma_reg;

  // Reciprocal tables: reset to unity gain, written only between blocks.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < BLOCK_COEFFS; i++) begin
          tbl_reg[s][i] <= RECIP_ONE;
        end
      end
    end else if (tbl_wr_ok) begin
      tbl_reg[tbl_sel][tbl_addr] <= tbl_data;
    end
  end

  // Beat sequencing, valid/last pipeline, write-rejection pulse and block count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat_reg      <= '0;
      chroma_reg    <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      tbl_err_reg   <= 1'b0;
      blk_count_reg <= '0;
    end else begin
      tbl_err_reg <= tbl_we & ~idle;
      if (fire) begin
        beat_reg <= (beat_reg == LAST_BEAT) ? '0 : beat_reg + BW'(1);
        if (beat_reg == '0) begin
          chroma_reg <= beat_chroma;
        end
      end
      if (adv) begin
        s1_valid_reg  <= fire;
        s1_last_reg   <= fire & (beat_reg == LAST_BEAT);
        out_valid_reg <= s1_valid_reg;
        out_last_reg  <= s1_last_reg;
      end
      if (out_valid_reg & out_ready & out_last_reg) begin
        blk_count_reg <= blk_count_reg + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [5:0] row;
    assign row = 6'(32'(beat_reg) * LANES + gi);

    quant_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .RECIP_W (RECIP_W)
    ) u_lane (
      .clk   (clk),
      .nrst  (nrst),
      .adv   (adv),
      .x     (in_data[gi*IN_W +: IN_W]),
      .recip (tbl_reg[beat_chroma][row]),
      .q     (out_data[gi*OUT_W +: OUT_W]),
      .sat   (out_sat[gi])
    );
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign tbl_err   = tbl_err_reg;
  assign blk_count = blk_count_reg;

endmodule

// File: tb/tb_quant_pipe.sv
// Randomised scoreboard bench for quant_pipe with an arithmetic reference model.
module tb_quant_pipe;
  import quant_pkg::*;

  localparam int LANES   = 8;
  localparam int IN_W    = 12;
  localparam int OUT_W   = 8;
  localparam int RECIP_W = 16;
  localparam int BEATS   = 64 / LANES;

  typedef struct packed {
    logic [LANES*OUT_W-1:0] data;
    logic [LANES-1:0]       sat;
    logic                   last;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [1:0]             in_comp = '0;
  logic [LANES*IN_W-1:0]  in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;
  logic                   out_last;
  logic                   tbl_we = 1'b0;
  logic                   tbl_sel = 1'b0;
  logic [5:0]             tbl_addr = '0;
  logic [RECIP_W:0]       tbl_data = '0;
  logic                   tbl_err;
  logic [15:0]            blk_count;

  quant_pipe #(
    .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .RECIP_W(RECIP_W)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_comp(in_comp), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_last(out_last),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_err(tbl_err), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          luma_m[64];
  int          chroma_m[64];
  int          tb_beat = 0;
  bit          tb_chroma = 1'b0;
  logic [15:0] blk_model = '0;
  int          err_pulses = 0;
  int          exp_err = 0;
  int          stall_cycles = 0;
  bit          rand_ready = 1'b0;
  bit          hold_prev = 1'b0;
  exp_t        prev;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the table value for raster index beat*LANES+lane.
  function automatic exp_t model(input logic [LANES*IN_W-1:0] d, input bit chroma, input int beat);
    exp_t e;
    e = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [IN_W-1:0]  raw;
      logic [OUT_W-1:0] b;
      longint x, a, r, qv;
      raw = d[l*IN_W +: IN_W];
      x   = longint'($signed(raw));
      r   = chroma ? chroma_m[beat*LANES+l] : luma_m[beat*LANES+l];
      a   = (x < 0) ? -x : x;
      qv  = (a * r + (64'd1 << (RECIP_W-1))) / (64'd1 << RECIP_W);
      if (x < 0) qv = -qv;
      if (qv > (1 << (OUT_W-1)) - 1) begin
        qv = (1 << (OUT_W-1)) - 1;
        e.sat[l] = 1'b1;
      end else if (qv < -(1 << (OUT_W-1))) begin
        qv = -(1 << (OUT_W-1));
        e.sat[l] = 1'b1;
      end
      b = qv[OUT_W-1:0];
      e.data[l*OUT_W +: OUT_W] = b;
    end
    e.last = (beat == BEATS-1);
    return e;
  endfunction

  function automatic logic [LANES*IN_W-1:0] pat(input int v0, input int v1, input int v2, input int v3);
    logic [LANES*IN_W-1:0] r;
    int v[4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int l = 0; l < LANES; l++) r[l*IN_W +: IN_W] = v[l%4][IN_W-1:0];
    return r;
  endfunction

  function automatic logic [LANES*IN_W-1:0] rnd_data();
    logic [LANES*IN_W-1:0] r;
    logic [IN_W-1:0] c;
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(0, 5))
        0:       c = {1'b0, {(IN_W-1){1'b1}}};
        1:       c = {1'b1, {(IN_W-1){1'b0}}};
        2:       c = IN_W'($urandom_range(0, 64) - 32);
        default: c = IN_W'($urandom);
      endcase
      r[l*IN_W +: IN_W] = c;
    end
    return r;
  endfunction

  // Downstream ready: forced low during a stall, otherwise random or always high.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_cycles > 0) begin
        out_ready = 1'b0;
        stall_cycles--;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks held outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        hold_prev = 1'b0;
        continue;
      end
      if (tbl_err) err_pulses++;
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev.data);
        chk("hold_sat", out_sat, prev.sat);
        chk("hold_last", out_last, prev.last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          $display("out beat data=%h sat=%b last=%b", out_data, out_sat, out_last);
          chk("out_data", out_data, e.data);
          chk("out_sat", out_sat, e.sat);
          chk("out_last", out_last, e.last);
          if (e.last) blk_model = blk_model + 16'd1;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev.data = out_data;
      prev.sat  = out_sat;
      prev.last = out_last;
    end
  end

  task automatic drive_beat(input logic [1:0] comp, input logic [LANES*IN_W-1:0] data);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_comp  = comp;
    in_data  = data;
    for (int t = 0; t <= 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (tb_beat == 0) tb_chroma = (comp == 2'd1) || (comp == 2'd2);
        sb.push_back(model(data, tb_chroma, tb_beat));
        tb_beat = (tb_beat + 1) % BEATS;
        done = 1'b1;
      end else if (t == 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles expected 1");
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [1:0] comp, input logic [LANES*IN_W-1:0] first,
                            input bit repeat_first, input bit gaps, input int stall_at);
    for (int b = 0; b < BEATS; b++) begin
      logic [LANES*IN_W-1:0] d;
      d = (b == 0 || repeat_first) ? first : rnd_data();
      if (b == stall_at) stall_cycles = 3;
      drive_beat((b == 0) ? comp : 2'($urandom_range(0, 3)), d);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic tbl_write(input logic sel, input logic [5:0] addr, input int val, input bit expect_ok);
    tbl_we   = 1'b1;
    tbl_sel  = sel;
    tbl_addr = addr;
    tbl_data = (RECIP_W+1)'(val);
    @(negedge clk);
    if (expect_ok) chk("tbl_wr_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    tbl_we = 1'b0;
    if (expect_ok) begin
      if (sel) chroma_m[addr] = val;
      else     luma_m[addr]   = val;
    end else begin
      exp_err++;
    end
    @(negedge clk);
    chk("tbl_err", tbl_err, !expect_ok);
    @(posedge clk); #1;
    if (!expect_ok) begin
      @(negedge clk);
      chk("tbl_err_pulse", tbl_err, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t <= 500; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
      if (t == 500) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    nrst     = 1'b0;
    in_valid = 1'b0;
    tbl_we   = 1'b0;
    sb.delete();
    tb_beat   = 0;
    blk_model = '0;
    for (int i = 0; i < 64; i++) begin
      luma_m[i]   = 1 << RECIP_W;
      chroma_m[i] = 1 << RECIP_W;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_sat", out_sat, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_tbl_err", tbl_err, 1'b0);
    chk("rst_blk_count", blk_count, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before 600us");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Unity gain with full-scale inputs saturates both ways.
    send_block(COMP_Y, pat(2047, -2048, 300, -1), 1'b0, 1'b0, -1);
    drain();
    chk("blk_count_1", blk_count, blk_model);

    // Whole luma table at Q=16; round-half-away cases.
    for (int a = 0; a < 64; a++) tbl_write(TBL_LUMA, 6'(a), recip_of(16), 1'b1);
    send_block(COMP_Y, pat(100, -40, 24, -8), 1'b1, 1'b0, -1);
    drain();

    // Chroma entry 0 at Q=32 used only by chroma blocks; mid-block comp noise ignored.
    tbl_write(TBL_CHROMA, 6'd0, recip_of(32), 1'b1);
    send_block(COMP_CR, pat(48, -48, 47, 49), 1'b1, 1'b0, -1);
    send_block(COMP_Y, pat(48, -48, 47, 49), 1'b1, 1'b0, -1);
    send_block(COMP_ALT_Y, pat(48, -48, 47, 49), 1'b1, 1'b0, -1);
    drain();

    // Downstream stalled from the start: two beats buffer, then in_ready drops.
    stall_cycles = 10;
    drive_beat(COMP_CB, rnd_data());
    drive_beat(COMP_Y, rnd_data());
    @(negedge clk);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    for (int b = 2; b < BEATS; b++) drive_beat(COMP_Y, rnd_data());
    drain();

    // Write attempted mid-block is dropped and flagged.
    for (int b = 0; b < 3; b++) drive_beat(COMP_Y, rnd_data());
    tbl_write(TBL_LUMA, 6'd60, 1234, 1'b0);
    for (int b = 3; b < BEATS; b++) drive_beat(COMP_Y, pat(2000, -2000, 1000, -1000));
    drain();

    // Write and input together while idle: write wins, beat taken next cycle with new entry.
    in_valid = 1'b1;
    in_comp  = COMP_Y;
    in_data  = pat(100, -100, 12, -12);
    tbl_we   = 1'b1;
    tbl_sel  = TBL_LUMA;
    tbl_addr = 6'd0;
    tbl_data = (RECIP_W+1)'(recip_of(8));
    @(negedge clk);
    chk("wr_wins_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    tbl_we = 1'b0;
    luma_m[0] = recip_of(8);
    drive_beat(COMP_Y, pat(100, -100, 12, -12));
    for (int b = 1; b < BEATS; b++) drive_beat(COMP_Y, rnd_data());
    drain();
    chk("blk_count_mid", blk_count, blk_model);

    // Random blocks, random backpressure, a 3-cycle mid-block stall, table reloads.
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      send_block(2'($urandom_range(0, 3)), rnd_data(), 1'b0, 1'b1, (k == 3) ? 4 : -1);
      if (k % 5 == 4) begin
        drain();
        chk("blk_count_rand", blk_count, blk_model);
        repeat (3) tbl_write(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                             recip_of(int'($urandom_range(1, 255))), 1'b1);
      end
    end
    drain();
    rand_ready = 1'b0;

    // Reset in the middle of a block: partial data discarded, tables back to unity.
    for (int b = 0; b < 5; b++) drive_beat(COMP_Y, rnd_data());
    do_reset();
    send_block(COMP_CB, pat(100, -40, 24, -8), 1'b1, 1'b0, -1);
    drain();
    chk("blk_count_after_rst", blk_count, 16'd1);
    chk("tbl_err_pulses", 32'(err_pulses), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
